// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin arbiter sharing one four-digit seven-segment driver
// Guarantees each client a minimum dwell and blanks the display between different sources.
module seg_display_arbiter #(
  parameter int NREQ         = 4,
  parameter int HOLD_CYCLES  = 100000000,
  parameter int BLANK_CYCLES = 1000000,
  parameter int CNT_W        = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   din_bus,
  input  logic [NREQ-1:0]      bcd_bus,
  input  logic [2*NREQ-1:0]    dec_bus,
  output logic [NREQ-1:0]      grant,
  output logic [2:0]           active_id,
  output logic [15:0]          disp_din,
  output logic                 disp_bcd,
  output logic [1:0]           disp_dec,
  output logic                 disp_enable
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_M1 = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [NREQ-1:0]    grant_n;
  logic [2:0]         id_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               cur_req, others, do_grant;

  // Round-robin search: first requester above the pointer, else wrap to the lowest one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i] && (i > int'(ptr))) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end

  assign cur_req = |(req & grant);
  assign others  = |(req & ~grant);

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    id_n     = active_id;
    cnt_n    = cnt;
    ptr_n    = ptr;
    do_grant = 1'b0;
    case (state)
      IDLE: begin
        grant_n = '0;
        id_n    = '0;
        if (|req) do_grant = 1'b1;
      end
      SHOW: begin
        if (!cur_req || ((cnt >= HOLD_M1) && others)) begin
          if (!others) begin
            state_n = IDLE;
            grant_n = '0;
            id_n    = '0;
            cnt_n   = '0;
          end else if (BLANK_CYCLES == 0) begin
            do_grant = 1'b1;
          end else begin
            state_n = BLANK;
            grant_n = '0;
            id_n    = '0;
            cnt_n   = '0;
          end
        end else if (cnt != HOLD_C) begin
          cnt_n = cnt + 1'b1;
        end
      end
      BLANK: begin
        if (cnt >= BLANK_M1) begin
          if (|req) begin
            do_grant = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        id_n    = '0;
        cnt_n   = '0;
      end
    endcase
    if (do_grant) begin
      state_n = SHOW;
      grant_n = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
      id_n    = 3'(win_idx);
      ptr_n   = win_idx;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      active_id   <= '0;
      disp_enable <= 1'b0;
      cnt         <= '0;
      ptr         <= PTR_W'(NREQ - 1);
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      active_id   <= id_n;
      disp_enable <= |grant_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
    end
  end

  // Client data is not latched: the granted channel's inputs pass straight through.
  always_comb begin
    disp_din = '0;
    disp_bcd = 1'b0;
    disp_dec = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        disp_din = disp_din | din_bus[16*i +: 16];
        disp_bcd = disp_bcd | bcd_bus[i];
        disp_dec = disp_dec | dec_bus[2*i +: 2];
      end
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed vector bench for seg_display_arbiter
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst0;
  logic [3:0]  req, req0;
  logic [15:0] din0;
  logic [63:0] din_bus;
  logic [3:0]  bcd_bus;
  logic [7:0]  dec_bus;

  logic [3:0]  grant, grant0;
  logic [2:0]  active_id, active_id0;
  logic [15:0] disp_din, disp_din0;
  logic        disp_bcd, disp_bcd0;
  logic [1:0]  disp_dec, disp_dec0;
  logic        disp_enable, disp_enable0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign din_bus = {16'h4444, 16'h3333, 16'h2222, din0};
  assign bcd_bus = 4'b1010;
  assign dec_bus = {2'd3, 2'd2, 2'd1, 2'd0};

  seg_display_arbiter #(.NREQ(4), .HOLD_CYCLES(8), .BLANK_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din_bus(din_bus), .bcd_bus(bcd_bus), .dec_bus(dec_bus),
    .grant(grant), .active_id(active_id), .disp_din(disp_din), .disp_bcd(disp_bcd),
    .disp_dec(disp_dec), .disp_enable(disp_enable)
  );

  seg_display_arbiter #(.NREQ(4), .HOLD_CYCLES(8), .BLANK_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .din_bus(din_bus), .bcd_bus(bcd_bus), .dec_bus(dec_bus),
    .grant(grant0), .active_id(active_id0), .disp_din(disp_din0), .disp_bcd(disp_bcd0),
    .disp_dec(disp_dec0), .disp_enable(disp_enable0)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] din0;
    int          n;
    logic [3:0]  g;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] id_of(input logic [3:0] g);
    id_of = 3'd0;
    for (int i = 0; i < 4; i++) if (g[i]) id_of = 3'(i);
  endfunction

  function automatic logic [25:0] expect_of(input logic [3:0] g);
    logic [2:0]  id;
    logic [15:0] d;
    logic        b;
    logic [1:0]  p;
    id = id_of(g);
    d = 16'h0; b = 1'b0; p = 2'd0;
    if (g != 4'b0000) begin
      d = din_bus[16*id +: 16];
      b = bcd_bus[id];
      p = dec_bus[2*id +: 2];
    end
    expect_of = {g, id, (g != 4'b0000), d, b, p};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [3:0] g);
    logic [25:0] exp_v;
    exp_v = expect_of(g);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got grant/id/en/din/bcd/dec=%h required %h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [15:0] d, input int n,
                     input logic [3:0] g);
    vec_t v;
    v.rst = r; v.req = q; v.din0 = d; v.n = n; v.g = g;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; din0 = 16'h1234;
    rst0 = 1'b1; req0 = 4'b0;

    // reset state, lone requester, live data, saturated dwell then competitor
    add(1, 4'b0000, 16'h1234, 2, 4'b0000);
    add(0, 4'b0001, 16'h1234, 50, 4'b0001);
    add(0, 4'b0001, 16'h5678, 1, 4'b0001);
    add(0, 4'b0011, 16'h5678, 2, 4'b0000);
    add(0, 4'b0011, 16'h5678, 8, 4'b0010);
    add(0, 4'b0000, 16'h5678, 2, 4'b0000);
    // two requesters alternate; pointer must restart at channel 0 after reset
    add(1, 4'b0000, 16'h1234, 1, 4'b0000);
    add(0, 4'b0101, 16'h1234, 8, 4'b0001);
    add(0, 4'b0101, 16'h1234, 2, 4'b0000);
    add(0, 4'b0101, 16'h1234, 8, 4'b0100);
    add(0, 4'b0101, 16'h1234, 2, 4'b0000);
    add(0, 4'b0101, 16'h1234, 8, 4'b0001);
    // all four requesting
    add(1, 4'b0000, 16'h1234, 1, 4'b0000);
    add(0, 4'b1111, 16'h1234, 8, 4'b0001);
    add(0, 4'b1111, 16'h1234, 2, 4'b0000);
    add(0, 4'b1111, 16'h1234, 8, 4'b0010);
    add(0, 4'b1111, 16'h1234, 2, 4'b0000);
    add(0, 4'b1111, 16'h1234, 8, 4'b0100);
    add(0, 4'b1111, 16'h1234, 2, 4'b0000);
    add(0, 4'b1111, 16'h1234, 8, 4'b1000);
    add(0, 4'b1111, 16'h1234, 2, 4'b0000);
    add(0, 4'b1111, 16'h1234, 8, 4'b0001);
    // granted channel drops early with another pending, then with nobody left at blank exit
    add(1, 4'b0000, 16'h1234, 1, 4'b0000);
    add(0, 4'b0010, 16'h1234, 2, 4'b0010);
    add(0, 4'b0011, 16'h1234, 1, 4'b0010);
    add(0, 4'b0001, 16'h1234, 2, 4'b0000);
    add(0, 4'b0001, 16'h1234, 3, 4'b0001);
    add(0, 4'b0010, 16'h1234, 1, 4'b0000);
    add(0, 4'b0000, 16'h1234, 3, 4'b0000);
    add(0, 4'b0100, 16'h1234, 1, 4'b0100);
    // reset during BLANK and during SHOW
    add(1, 4'b0000, 16'h1234, 1, 4'b0000);
    add(0, 4'b0011, 16'h1234, 8, 4'b0001);
    add(0, 4'b0011, 16'h1234, 1, 4'b0000);
    add(1, 4'b1000, 16'h1234, 1, 4'b0000);
    add(0, 4'b1000, 16'h1234, 3, 4'b1000);
    add(1, 4'b1000, 16'h1234, 1, 4'b0000);
    add(0, 4'b1000, 16'h1234, 2, 4'b1000);

    for (int v = 0; v < tbl.size(); v++) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        rst  = tbl[v].rst;
        req  = tbl[v].req;
        din0 = tbl[v].din0;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d.%0d", v, k),
              {grant, active_id, disp_enable, disp_din, disp_bcd, disp_dec}, tbl[v].g);
      end
    end

    // zero-length blank: direct hand-over with enable held high
    rst = 1'b1; req = 4'b0; din0 = 16'h1234;
    rst0 = 1'b1; req0 = 4'b0000;
    @(posedge clk);
    #1;
    check("nb_reset", {grant0, active_id0, disp_enable0, disp_din0, disp_bcd0, disp_dec0}, 4'b0000);
    rst0 = 1'b0; req0 = 4'b0011;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("nb_cyc%0d", c),
            {grant0, active_id0, disp_enable0, disp_din0, disp_bcd0, disp_dec0},
            (c <= 8) ? 4'b0001 : ((c <= 16) ? 4'b0010 : 4'b0001));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
